operand_capture: RTL
====================

# operand_capture

Upstream front-end for the ALU operation multiplexer. Conditions the raw centre push-button with a synchronizer, debounce filter and edge detector. Sequences successive presses to latch operand A, then operand B plus the operation code, from the switch bank. Then issues a single-cycle execute pulse, so the multiplexer sees stable registered operands and one clean enable per operation instead of a bouncing button level.

## Interface
- `DATA_W`, default 8: operand width.
- `OP_W`, default 4: operation-selector width.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Minimum 2.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high. Clears all state.
- `btn_in` input 1: raw asynchronous push-button (btnC).
- `data_in` input DATA_W: switch operand value (sw[15:8]).
- `op_in` input OP_W: switch operation code (sw[3:0]).
- `a_val` output DATA_W: latched operand A.
- `b_val` output DATA_W: latched operand B.
- `op_val` output OP_W: latched operation code.
- `go` output 1: one-cycle execute pulse to the multiplexer.
- `phase` output 2: current FSM state, for LED indication.
- `press` output 1: one-cycle accepted-press strobe, for debug and LED.

## Operation
**Reset values**
- a_val = 0, b_val = 0, op_val = 0, go = 0, press = 0, phase = LOAD_A (2'd0).
- Synchronizer flops = 0, debounced level = 0, debounce counter = 0.

**Button conditioning**
- btn_in passes through a 2-flop synchronizer, giving btn_s.
- The counter increments while btn_s ≠ debounced level. It clears to 0 on any cycle where they are equal.
- When the counter reaches DEBOUNCE_CYCLES−1 with a mismatch, the debounced level takes btn_s and the counter clears.
- press is asserted for exactly one cycle after a 0→1 transition of the debounced level. Releases produce no event.
- The counter width is clog2(DEBOUNCE_CYCLES). The counter never wraps, because it saturates by clearing at the terminal count.

**FSM** (states: LOAD_A = 0, LOAD_B = 1, EXEC = 2, SHOW = 3)
- LOAD_A, press: a_val ← data_in; go to LOAD_B.
- LOAD_B, press: b_val ← data_in and op_val ← op_in, in the same cycle; go to EXEC.
- EXEC: go = 1 for this one cycle; go to SHOW unconditionally. A press coinciding with EXEC is discarded.
- SHOW, press: go to LOAD_A. a_val, b_val and op_val hold their values until overwritten by the next capture.
- Every state holds its value when press = 0.
- Each capture register updates only in its own capture cycle. The switches are sampled on the press cycle.

**Reset and boundary cases**
- Reset mid-sequence: return to LOAD_A with all operands cleared. Any partially counted debounce is discarded.
- A button held through reset produces one press DEBOUNCE_CYCLES after btn_s settles high post-reset.
- reset has priority over press in the same cycle.

## Timing
- Press latency: a btn_in rising edge that is clean from then on yields press exactly 2 + DEBOUNCE_CYCLES + 1 cycles later.
- Capture: the register update is visible on the cycle after press.
- Execute: go is asserted on the cycle after the LOAD_B capture edge. go is never asserted in two consecutive cycles.
- Bounce shorter than DEBOUNCE_CYCLES cycles in either direction produces no press.
- Two accepted presses are separated by at least 2·DEBOUNCE_CYCLES cycles.

## Configuration
- `OPERAND_CAPTURE_DEBOUNCE_EN`
  - Defined (board builds): the debounce filter is present as described.
  - Undefined: the filter is removed. The debounced level equals btn_s directly, and press = rising edge of btn_s, giving a latency of 3 cycles. The DEBOUNCE_CYCLES parameter is ignored.

## Test plan
Benches use DEBOUNCE_CYCLES = 4 with the macro defined unless noted.
- Reset, then idle 20 cycles -> a_val = b_val = 0, op_val = 0, phase = 0, go never asserted.
- data_in = 8'h3C, clean press -> press exactly 7 cycles after the edge; a_val = 8'h3C next cycle; phase = 1.
- data_in = 8'h05, op_in = 4'h2, press; then wait -> b_val = 8'h05 and op_val = 4'h2; go high for exactly one cycle; phase = 3. A further press -> phase = 0 with operands unchanged.
- Bounce btn_in 1/0 on alternating cycles for 3-cycle bursts, then hold high -> exactly one press; no press on release.
- Reset asserted while phase = 1 with a_val = 8'h3C -> next cycle phase = 0, a_val = 0, go = 0.
- Macro undefined: clean press -> press 3 cycles after the edge; the full A/B/EXEC sequence completes with go pulsed once.

Source files
------------

// File: rtl/operand_capture.sv
// rtl/operand_capture.sv - button-sequenced operand/opcode capture with execute pulse; filter enabled by OPERAND_CAPTURE_DEBOUNCE_EN
module operand_capture #(
    parameter int DATA_W          = 8,
    parameter int OP_W            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [OP_W-1:0]   op_in,
    output logic [DATA_W-1:0] a_val,
    output logic [DATA_W-1:0] b_val,
    output logic [OP_W-1:0]   op_val,
    output logic              go,
    output logic [1:0]        phase,
    output logic              press
);

    // The filter needs at least two stable cycles to be meaningful.
    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("operand_capture: DEBOUNCE_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic sync1_q;
    logic btn_s_q;
    logic level;
    logic level_prev_q;
    logic press_q;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            btn_s_q <= sync1_q;
        end
    end

`ifdef OPERAND_CAPTURE_DEBOUNCE_EN
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Count consecutive mismatch cycles; accept the new level at the terminal count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (btn_s_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter and accepted level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    // Without the filter the synchronized button is taken as the level directly.
    assign level = btn_s_q;
`endif

    // Rising-edge detector on the accepted level; releases are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            level_prev_q <= level;
            press_q      <= level & ~level_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Capture sequencer
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic              cap_a;
    logic              cap_b;
    logic              exec_pulse;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;

    // Next-state and capture-enable decode; a press landing in EXEC is dropped.
    always_comb begin
        state_d    = state_q;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        exec_pulse = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (press_q) begin
                    cap_a   = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press_q) begin
                    cap_b   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_pulse = 1'b1;
                state_d    = SHOW;
            end
            SHOW: begin
                if (press_q) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers; each loads only in its own capture cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            if (cap_a) begin
                a_q <= data_in;
            end
            if (cap_b) begin
                b_q  <= data_in;
                op_q <= op_in;
            end
        end
    end

    assign a_val  = a_q;
    assign b_val  = b_q;
    assign op_val = op_q;
    assign go     = exec_pulse;
    assign phase  = state_q;
    assign press  = press_q;

endmodule
